// File: rtl/maze_vga_renderer.sv
// Maze raster engine: snapshots the game state once per frame and scans it out
// as VGA video in square cells, with a one-clock draw-done strobe per frame.
module maze_vga_renderer #(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CELL_SHIFT = 4,
  parameter int ROW        = 40,
  parameter int COLUMN     = 30
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic [ROW*COLUMN-1:0] i_Map,
  input  logic [6:0]            i_PlayerX,
  input  logic [5:0]            i_PlayerY,
  input  logic [6:0]            i_Col,
  input  logic [5:0]            i_Row,
  input  logic                  i_fRunning,
  output logic                  o_fRed,
  output logic                  o_fGreen,
  output logic                  o_fBlue,
  output logic                  o_hSync,
  output logic                  o_vSync,
  output logic                  o_fDrawDone
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MAP_BITS = ROW * COLUMN;
  localparam int MAP_IW   = (MAP_BITS > 1) ? $clog2(MAP_BITS) : 1;
  localparam int IDX_W    = 11;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [2:0] {
    BLACK = 3'b000,
    BLUE  = 3'b001,
    GREEN = 3'b010,
    RED   = 3'b100,
    WHITE = 3'b111
  } colour_t;

  logic [DW-1:0] divCnt;
  logic          pixEn;
  logic [HW-1:0] hCnt;
  logic [VW-1:0] vCnt;
  logic          lineWrap;
  logic          frameWrap;
  logic          lastActive;

  assign pixEn      = (divCnt == DIV_LAST);
  assign lineWrap   = (hCnt == H_LAST);
  assign frameWrap  = lineWrap && (vCnt == V_LAST);
  assign lastActive = (hCnt == H_ACT_LAST) && (vCnt == V_ACT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      divCnt <= '0;
      hCnt   <= '0;
      vCnt   <= '0;
    end else begin
      divCnt <= pixEn ? '0 : divCnt + 1'b1;
      if (pixEn) begin
        if (lineWrap) begin
          hCnt <= '0;
          vCnt <= (vCnt == V_LAST) ? '0 : vCnt + 1'b1;
        end else begin
          hCnt <= hCnt + 1'b1;
        end
      end
    end
  end

  logic [MAP_BITS-1:0] shMap;
  logic [6:0]          shPlayerX;
  logic [5:0]          shPlayerY;
  logic [6:0]          shCol;
  logic [5:0]          shRow;
  logic                shRunning;

  // NOTE: the map snapshot is a wide register, not a RAM, so it takes the async reset like any flop.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      shMap     <= '0;
      shPlayerX <= '0;
      shPlayerY <= '0;
      shCol     <= '0;
      shRow     <= '0;
      shRunning <= 1'b0;
    end else if (pixEn && frameWrap) begin
      shMap     <= i_Map;
      shPlayerX <= i_PlayerX;
      shPlayerY <= i_PlayerY;
      shCol     <= i_Col;
      shRow     <= i_Row;
      shRunning <= i_fRunning;
    end
  end

  logic [IDX_W-1:0]  cx;
  logic [IDX_W-1:0]  cy;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  colExt;
  logic [IDX_W-1:0]  rowExt;
  logic [MAP_IW-1:0] bitSel;
  logic              mapBit;
  logic              active;
  logic              outOfRange;
  logic              isPlayer;
  logic              isGoal;

  assign cx     = IDX_W'(hCnt >> CELL_SHIFT);
  assign cy     = IDX_W'(vCnt >> CELL_SHIFT);
  assign idx    = cy * IDX_W'(ROW) + cx;
  assign colExt = IDX_W'(shCol);
  assign rowExt = IDX_W'(shRow);
  // Map is MSB first: cell 0 lives in the top bit.
  assign bitSel = MAP_IW'(IDX_W'(MAP_BITS - 1) - idx);
  assign mapBit = shMap[bitSel];

  assign active     = (hCnt < H_ACT) && (vCnt < V_ACT);
  assign outOfRange = (cx >= colExt) || (cy >= rowExt);
  assign isPlayer   = (cx == IDX_W'(shPlayerX)) && (cy == IDX_W'(shPlayerY));
  assign isGoal     = (cx == colExt - IDX_W'(2)) && (cy == rowExt - IDX_W'(2));

  colour_t colour;

  // NOTE: colour gets a default before any branch so this block cannot infer a latch.
  always_comb begin
    colour = BLACK;
    if (active && shRunning) begin
      if (outOfRange)    colour = BLUE;
      else if (isPlayer) colour = RED;
      else if (isGoal)   colour = GREEN;
      else if (mapBit)   colour = WHITE;
    end
  end

  logic hSyncNext;
  logic vSyncNext;

  assign hSyncNext = !((hCnt >= HS_START) && (hCnt <= HS_END));
  assign vSyncNext = !((vCnt >= VS_START) && (vCnt <= VS_END));

  // Colour and syncs share one register stage so they stay aligned at the pins.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      o_fRed      <= 1'b0;
      o_fGreen    <= 1'b0;
      o_fBlue     <= 1'b0;
      o_hSync     <= 1'b1;
      o_vSync     <= 1'b1;
      o_fDrawDone <= 1'b0;
    end else begin
      o_fDrawDone <= pixEn && lastActive;
      if (pixEn) begin
        {o_fRed, o_fGreen, o_fBlue} <= colour;
        o_hSync <= hSyncNext;
        o_vSync <= vSyncNext;
      end
    end
  end

endmodule

// File: doc/maze_vga_renderer.md
Name: maze_vga_renderer

Overview:
Raster engine that turns the game core's maze bitmap and player position into 640x480 VGA video. It sits downstream of the game-state controller. Each frame it snapshots that controller's map, dimensions and player coordinates, then scans them out as 16x16-pixel cells. At the end of every active frame it returns the one-cycle draw-done strobe that the controller waits on before committing a move.

Parameters:
- CLK_DIV, 2, i_Clk cycles per pixel (50 MHz clock gives a 25 MHz pixel rate).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, horizontal sync width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BP, 33, vertical back porch, in lines.
- CELL_SHIFT, 4, log2 of cell size in pixels (16x16 cells).
- ROW, 40, grid cells per line; also the map row stride.
- COLUMN, 30, grid cell rows.

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  asynchronous, active-low reset.
- i_Map  in  ROW*COLUMN  maze bitmap; 1 = wall. Cell (x,y) is bit ROW*COLUMN-1-(y*ROW+x), MSB first.
- i_PlayerX  in  7  player cell column.
- i_PlayerY  in  6  player cell row.
- i_Col  in  7  active maze width in cells.
- i_Row  in  6  active maze height in cells.
- i_fRunning  in  1  game active; 0 blanks the playfield to black.
- o_fRed  out  1  red enable (top replicates to 8 bits).
- o_fGreen  out  1  green enable.
- o_fBlue  out  1  blue enable.
- o_hSync  out  1  horizontal sync, active-low.
- o_vSync  out  1  vertical sync, active-low.
- o_fDrawDone  out  1  one-i_Clk pulse after the last active pixel of a frame.

Behaviour:
- Reset is asynchronous: i_Rst low takes effect immediately and holds until i_Rst goes high.
- Values while i_Rst is low:
  - pixel divider, h counter and v counter = 0;
  - o_fRed, o_fGreen, o_fBlue = 0;
  - o_hSync = 1, o_vSync = 1;
  - o_fDrawDone = 0;
  - all snapshot registers = 0.
- Pixel enable:
  - div counter runs 0..CLK_DIV-1; pix_en is asserted when it equals CLK_DIV-1.
  - All h/v counting and output updates occur only on pix_en.
- Horizontal counter:
  - hcnt runs 0..H_TOTAL-1, where H_TOTAL = 800.
  - On wrap to 0, vcnt increments, wrapping at V_TOTAL-1, where V_TOTAL = 525.
- Sync generation:
  - hSync is low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
  - vSync is low for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
- Snapshot:
  - On the pix_en where the counters wrap to (0,0), latch i_Map, i_PlayerX, i_PlayerY, i_Col, i_Row and i_fRunning into shadow registers.
  - The whole frame is drawn from the shadows. Input changes mid-frame never tear the image.
- Cell addressing: cx = hcnt >> CELL_SHIFT, cy = vcnt >> CELL_SHIFT, idx = cy*ROW + cx (11-bit).
- Colour priority, evaluated only in the active area (hcnt < 640 and vcnt < 480):
  1. shadow running = 0: black (000).
  2. cx >= Col or cy >= Row: blue (001).
  3. cx == PlayerX and cy == PlayerY: red (100).
  4. cx == Col-2 and cy == Row-2 (goal cell): green (010).
  5. map bit set: white (111).
  6. otherwise: black (000).
- Colour in blanking is always 000.
- Output pipeline:
  - RGB and both syncs are registered together on pix_en.
  - Latency is exactly 1 pixel (CLK_DIV clocks) from counter value to pins, identical for colour and sync.
- Draw-done strobe:
  - o_fDrawDone = 1 for exactly one i_Clk cycle, on the clock following the pix_en where hcnt = 639 and vcnt = 479.
  - Period is 420000 pixels (840000 clocks at CLK_DIV = 2).
  - It never asserts during reset or in any other cycle.
- Boundary conditions:
  - Col/Row of 0 or above 40/30: everything out of range renders blue; no wrap-around into adjacent rows.
  - A player position on a wall cell still renders red.
  - Reset mid-frame restarts from (0,0) with a fresh snapshot at the first wrap.

Test Plan:
- Reset release → first o_hSync fall at pixel 656 (clock 1313 at CLK_DIV = 2, ±1); low for 96 pixels; line period 1600 clocks.
- Free run for two frames → vSync low on lines 490–491 only; o_fDrawDone pulses are 840000 clocks apart, each exactly 1 clock wide.
- i_Map = bit 1199 only, Col = 40, Row = 30, running = 1, player at (5,5) → pixels (0..15, 0..15) white; (80..95, 80..95) red; (608..623, 448..463) green; all others black.
- Col = 10, Row = 8 → pixel (160,0) and pixel (0,128) blue; pixel (144,112), i.e. cell (9,7), not blue.
- Change i_PlayerX from 5 to 6 at line 200 → the current frame still shows red at cx = 5; the next frame shows red at cx = 6.
- i_fRunning = 0 → all RGB stay 0 for a whole frame while sync timing and o_fDrawDone continue unchanged.
